// File: rtl/dbg_sba_master.sv
// Debug system-bus access engine.
// Turns debug-module read/write commands into DEBUG_BUS master transactions.
// A command may cover several word beats; the address auto-increments by 4
// per beat and wraps at the top of the address space. Only one bus
// transaction is in flight at a time. Each beat produces one response that
// must be handshaked before the next beat is issued. A gnt/r_valid timeout
// ends the command with an error response.
module dbg_sba_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_we,
  input  logic [3:0]            cmd_be,
  input  logic [31:0]           cmd_wdata,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  rsp_last,
  output logic                  dbg_req,
  output logic [ADDR_WIDTH-1:0] dbg_add,
  output logic                  dbg_wen,
  output logic [31:0]           dbg_wdata,
  output logic [3:0]            dbg_be,
  input  logic                  dbg_gnt,
  input  logic                  dbg_r_valid,
  input  logic [31:0]           dbg_r_rdata,
  input  logic                  dbg_r_opc,
  output logic                  busy
);

  // Timeout counter is wide enough to hold TIMEOUT-1; TIMEOUT=0 disables it.
  localparam int              TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int              TMO_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [TW-1:0]   TMO_LAST   = TW'(TMO_LAST_I);
  localparam bit              TMO_EN     = (TIMEOUT > 0);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RSP} state_e;

  state_e                 state_q;
  logic                   cmd_ready_q;
  logic                   req_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   we_q;
  logic [3:0]             be_q;
  logic [31:0]            wdata_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   beat_q;
  logic [TW-1:0]          tmo_q;
  logic                   rsp_valid_q;
  logic [31:0]            rsp_rdata_q;
  logic                   rsp_err_q;
  logic                   rsp_timeout_q;
  logic                   rsp_last_q;

  logic [ADDR_WIDTH-1:0]  addr_d;
  logic                   tmo_hit_d;
  logic                   last_beat_d;

  // Next beat address, timeout expiry and last-beat detection.
  always_comb begin
    addr_d      = addr_q + ADDR_WIDTH'(4);
    tmo_hit_d   = TMO_EN && (tmo_q == TMO_LAST);
    last_beat_d = (beat_q == len_q);
  end

  // Command/bus/response sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b1;
      req_q         <= 1'b0;
      addr_q        <= '0;
      we_q          <= 1'b0;
      be_q          <= '0;
      wdata_q       <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      tmo_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_last_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q      <= cmd_addr & ~ADDR_WIDTH'(3);
            we_q        <= cmd_we;
            be_q        <= cmd_be;
            wdata_q     <= cmd_wdata;
            len_q       <= cmd_len;
            beat_q      <= '0;
            tmo_q       <= '0;
            req_q       <= 1'b1;
            cmd_ready_q <= 1'b0;
            state_q     <= S_REQ;
          end
        end
        S_REQ: begin
          // A grant in the expiry cycle still wins over the timeout.
          if (dbg_gnt) begin
            req_q   <= 1'b0;
            tmo_q   <= '0;
            state_q <= S_WAIT;
          end else if (tmo_hit_d) begin
            req_q         <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_last_q    <= 1'b1;
            state_q       <= S_RSP;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_WAIT: begin
          // Only reached after the grant edge, so r_valid coincident with
          // gnt was never looked at.
          if (dbg_r_valid) begin
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= we_q ? 32'h0 : dbg_r_rdata;
            rsp_err_q     <= dbg_r_opc;
            rsp_timeout_q <= 1'b0;
            rsp_last_q    <= dbg_r_opc | last_beat_d;
            state_q       <= S_RSP;
          end else if (tmo_hit_d) begin
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_last_q    <= 1'b1;
            state_q       <= S_RSP;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_RSP: begin
          // Bus stays idle until the response is consumed.
          if (rsp_ready) begin
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_last_q    <= 1'b0;
            if (rsp_last_q) begin
              cmd_ready_q <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              addr_q  <= addr_d;
              beat_q  <= beat_q + LEN_WIDTH'(1);
              tmo_q   <= '0;
              req_q   <= 1'b1;
              state_q <= S_REQ;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign dbg_req     = req_q;
  assign dbg_add     = addr_q;
  assign dbg_wen     = ~we_q;
  assign dbg_wdata   = wdata_q;
  assign dbg_be      = be_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_last    = rsp_last_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_dbg_sba_master.sv
// Bench for dbg_sba_master: table of single accesses plus directed
// sequences for bursts, error abort, timeout, stalls and mid-transfer reset.
module tb_dbg_sba_master;
  localparam int AW  = 32;
  localparam int LW  = 8;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          cmd_we;
  logic [3:0]    cmd_be;
  logic [31:0]   cmd_wdata;
  logic [LW-1:0] cmd_len;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          rsp_last;
  logic          dbg_req;
  logic [AW-1:0] dbg_add;
  logic          dbg_wen;
  logic [31:0]   dbg_wdata;
  logic [3:0]    dbg_be;
  logic          dbg_gnt     = 1'b0;
  logic          dbg_r_valid = 1'b0;
  logic [31:0]   dbg_r_rdata = 32'h0;
  logic          dbg_r_opc   = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  dbg_sba_master #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_we(cmd_we), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .rsp_last(rsp_last),
    .dbg_req(dbg_req), .dbg_add(dbg_add), .dbg_wen(dbg_wen), .dbg_wdata(dbg_wdata),
    .dbg_be(dbg_be), .dbg_gnt(dbg_gnt), .dbg_r_valid(dbg_r_valid),
    .dbg_r_rdata(dbg_r_rdata), .dbg_r_opc(dbg_r_opc), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bus slave model: grant after gnt_wait cycles (-1 = never), r_valid
  // rv_wait cycles after the cycle following gnt, r_opc=1 on beat err_beat,
  // read data = slv_rdata + beat index. Granted requests are logged.
  int          gnt_wait  = 0;
  int          rv_wait   = 0;
  int          err_beat  = -1;
  logic [31:0] slv_rdata = 32'h0;
  int          log_base  = 0;
  int          rv_seen   = 0;
  logic [31:0] q_add[$];
  logic [31:0] q_wdata[$];
  logic        q_wen[$];
  logic [3:0]  q_be[$];
  logic [31:0] r_rdata[$];
  logic        r_err[$];
  logic        r_tmo[$];
  logic        r_last[$];

  int          gcnt    = 0;
  int          rv_cnt  = 0;
  bit          rv_pend = 1'b0;
  logic        rv_opc  = 1'b0;
  logic [31:0] rv_data = 32'h0;

  always begin
    @(posedge clk);
    #1;
    dbg_gnt     = 1'b0;
    dbg_r_valid = 1'b0;
    dbg_r_rdata = 32'h0;
    dbg_r_opc   = 1'b0;
    if (rv_pend) begin
      if (rv_cnt == 0) begin
        dbg_r_valid = 1'b1;
        dbg_r_rdata = rv_data;
        dbg_r_opc   = rv_opc;
        rv_pend     = 1'b0;
        rv_seen++;
      end else begin
        rv_cnt--;
      end
    end else if (dbg_req) begin
      if (gnt_wait >= 0 && gcnt >= gnt_wait) begin
        dbg_gnt = 1'b1;
        rv_opc  = ((q_add.size() - log_base) == err_beat);
        rv_data = slv_rdata + 32'(q_add.size() - log_base);
        q_add.push_back(dbg_add);
        q_wdata.push_back(dbg_wdata);
        q_wen.push_back(dbg_wen);
        q_be.push_back(dbg_be);
        rv_pend = 1'b1;
        rv_cnt  = rv_wait;
        gcnt    = 0;
      end else begin
        gcnt++;
      end
    end else begin
      gcnt = 0;
    end
  end

  // Response log: one entry per handshake.
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      r_rdata.push_back(rsp_rdata);
      r_err.push_back(rsp_err);
      r_tmo.push_back(rsp_timeout);
      r_last.push_back(rsp_last);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one cycle; the engine must be idle.
  task automatic issue(input logic we, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input logic [7:0] len);
    chk("cmd_ready_before_issue", cmd_ready, 1);
    cmd_we    = we;
    cmd_addr  = a;
    cmd_be    = be;
    cmd_wdata = wd;
    cmd_len   = len;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n;
    n = 0;
    while ((busy || rsp_valid) && n < budget) begin
      step();
      n++;
    end
    chk(nm, busy, 0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] bus_rdata;
    int          err_beat;
    logic [31:0] exp_add;
    logic        exp_wen;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        vt[4];
  logic [31:0] burst_add[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int qb, rb, cyc, n, bad;

    vt[0] = '{1'b0, 32'h1A10_0000, 4'hF, 32'h0,         32'hDEAD_BEEF, -1, 32'h1A10_0000, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vt[1] = '{1'b1, 32'h0000_1003, 4'h3, 32'h1234_5678, 32'h5555_5555, -1, 32'h0000_1000, 1'b0, 32'h0,         1'b0};
    vt[2] = '{1'b0, 32'h8000_0004, 4'hF, 32'h0,         32'h0BAD_C0DE,  0, 32'h8000_0004, 1'b1, 32'h0BAD_C0DE, 1'b1};
    vt[3] = '{1'b1, 32'hFFFF_FFFC, 4'hC, 32'hA5A5_A5A5, 32'h0,          0, 32'hFFFF_FFFC, 1'b0, 32'h0,         1'b1};
    burst_add[0] = 32'hFFFF_FFF8;
    burst_add[1] = 32'hFFFF_FFFC;
    burst_add[2] = 32'h0000_0000;
    burst_add[3] = 32'h0000_0004;

    cmd_valid = 1'b0; cmd_addr = '0; cmd_we = 1'b0; cmd_be = '0;
    cmd_wdata = '0;   cmd_len = '0;  rsp_ready = 1'b1; rst = 1'b1;
    step();
    step();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_req",       dbg_req,   0);
    chk("rst_wen",       dbg_wen,   1);
    chk("rst_add",       dbg_add,   0);
    chk("rst_wdata",     dbg_wdata, 0);
    chk("rst_be",        dbg_be,    0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_last",  rsp_last,  0);
    chk("rst_busy",      busy,      0);
    rst = 1'b0;
    step();

    // Single accesses, zero-wait bus.
    for (int i = 0; i < 4; i++) begin
      gnt_wait = 0; rv_wait = 0; err_beat = vt[i].err_beat; slv_rdata = vt[i].bus_rdata;
      qb = q_add.size(); rb = r_rdata.size(); log_base = qb;
      issue(vt[i].we, vt[i].addr, vt[i].be, vt[i].wdata, 8'd0);
      cyc = 1;
      while (!rsp_valid && cyc < 20) begin
        step();
        cyc++;
      end
      chk("vec_latency", cyc, 3);
      wait_idle(20, "vec_idle");
      chk("vec_nreq", q_add.size() - qb, 1);
      chk("vec_nrsp", r_rdata.size() - rb, 1);
      if (q_add.size() == qb + 1) begin
        chk("vec_add",   q_add[qb],   vt[i].exp_add);
        chk("vec_wen",   q_wen[qb],   vt[i].exp_wen);
        chk("vec_wdata", q_wdata[qb], vt[i].wdata);
        chk("vec_be",    q_be[qb],    vt[i].be);
      end
      if (r_rdata.size() == rb + 1) begin
        chk("vec_rdata", r_rdata[rb], vt[i].exp_rdata);
        chk("vec_err",   r_err[rb],   vt[i].exp_err);
        chk("vec_tmo",   r_tmo[rb],   0);
        chk("vec_last",  r_last[rb],  1);
      end
    end

    // Write fill burst crossing the top of the address space.
    gnt_wait = 0; rv_wait = 0; err_beat = -1; slv_rdata = 32'h0;
    qb = q_add.size(); rb = r_rdata.size(); log_base = qb;
    issue(1'b1, 32'hFFFF_FFF8, 4'hF, 32'hA5A5_A5A5, 8'd3);
    wait_idle(60, "burst_idle");
    chk("burst_nreq", q_add.size() - qb, 4);
    chk("burst_nrsp", r_rdata.size() - rb, 4);
    if (q_add.size() == qb + 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("burst_add",   q_add[qb+k],   burst_add[k]);
        chk("burst_wen",   q_wen[qb+k],   0);
        chk("burst_wdata", q_wdata[qb+k], 32'hA5A5_A5A5);
      end
    end
    if (r_rdata.size() == rb + 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("burst_last",  r_last[rb+k],  (k == 3));
        chk("burst_err",   r_err[rb+k],   0);
        chk("burst_rdata", r_rdata[rb+k], 0);
      end
    end

    // Read burst aborted by a bus error on beat 1.
    err_beat = 1; slv_rdata = 32'h0000_0100;
    qb = q_add.size(); rb = r_rdata.size(); log_base = qb;
    issue(1'b0, 32'h3000_0000, 4'hF, 32'h0, 8'd2);
    wait_idle(40, "abort_idle");
    repeat (5) step();
    chk("abort_nreq", q_add.size() - qb, 2);
    chk("abort_nrsp", r_rdata.size() - rb, 2);
    if (q_add.size() == qb + 2) chk("abort_add1", q_add[qb+1], 32'h3000_0004);
    if (r_rdata.size() == rb + 2) begin
      chk("abort_rdata0", r_rdata[rb],   32'h0000_0100);
      chk("abort_err0",   r_err[rb],     0);
      chk("abort_last0",  r_last[rb],    0);
      chk("abort_rdata1", r_rdata[rb+1], 32'h0000_0101);
      chk("abort_err1",   r_err[rb+1],   1);
      chk("abort_last1",  r_last[rb+1],  1);
    end

    // Grant withheld: request must drop after TIMEOUT cycles.
    gnt_wait = -1; err_beat = -1;
    qb = q_add.size(); rb = r_rdata.size(); log_base = qb;
    issue(1'b0, 32'h2000_0000, 4'hF, 32'h0, 8'd5);
    n = 0;
    while (dbg_req && n < 50) begin
      n++;
      step();
    end
    chk("tmo_req_cycles", n, TMO);
    chk("tmo_rsp_valid",  rsp_valid,   1);
    chk("tmo_rsp_err",    rsp_err,     1);
    chk("tmo_rsp_tmo",    rsp_timeout, 1);
    chk("tmo_rsp_last",   rsp_last,    1);
    chk("tmo_rsp_rdata",  rsp_rdata,   0);
    wait_idle(20, "tmo_idle");
    n = 0;
    for (int k = 0; k < 6; k++) begin
      if (dbg_req) n++;
      step();
    end
    chk("tmo_no_more_req", n, 0);
    chk("tmo_nrsp", r_rdata.size() - rb, 1);
    chk("tmo_nreq", q_add.size() - qb, 0);

    // Grant stalled 3 cycles, then response back-pressured for 5 cycles.
    gnt_wait = 3; rv_wait = 0; slv_rdata = 32'h0000_0077; rsp_ready = 1'b0;
    rb = r_rdata.size(); log_base = q_add.size();
    issue(1'b0, 32'h0000_0040, 4'hF, 32'h0, 8'd0);
    n = 0; bad = 0;
    while (dbg_req && n < 20) begin
      if (dbg_add !== 32'h40 || dbg_wen !== 1'b1 || cmd_ready !== 1'b0) bad++;
      n++;
      step();
    end
    chk("stall_req_cycles", n, 4);
    chk("stall_req_stable", bad, 0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      if (cmd_ready !== 1'b0) bad++;
      n++;
      step();
    end
    chk("stall_rsp_seen", rsp_valid, 1);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h77 || rsp_last !== 1'b1 ||
          cmd_ready !== 1'b0 || dbg_req !== 1'b0) bad++;
      step();
    end
    chk("stall_rsp_stable", bad, 0);
    rsp_ready = 1'b1;
    step();
    chk("stall_done_ready", cmd_ready, 1);
    chk("stall_done_valid", rsp_valid, 0);
    chk("stall_nrsp", r_rdata.size() - rb, 1);
    if (r_rdata.size() == rb + 1) chk("stall_rdata", r_rdata[rb], 32'h77);

    // Reset while waiting for r_valid; the late r_valid must be ignored.
    gnt_wait = 0; rv_wait = 4; slv_rdata = 32'h0000_0099;
    rb = r_rdata.size(); log_base = q_add.size(); n = rv_seen;
    issue(1'b0, 32'h0000_0050, 4'hF, 32'h0, 8'd0);
    step();
    chk("rstw_in_wait_busy", busy, 1);
    chk("rstw_in_wait_req",  dbg_req, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstw_busy",  busy, 0);
    chk("rstw_ready", cmd_ready, 1);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
      step();
    end
    chk("rstw_stray_ignored", bad, 0);
    chk("rstw_stray_seen", rv_seen - n, 1);
    chk("rstw_nrsp", r_rdata.size() - rb, 0);

    // Normal read after the reset.
    rv_wait = 0; slv_rdata = 32'h1357_9BDF;
    rb = r_rdata.size(); log_base = q_add.size();
    issue(1'b0, 32'h0000_0060, 4'hF, 32'h0, 8'd0);
    wait_idle(20, "post_idle");
    chk("post_nrsp", r_rdata.size() - rb, 1);
    if (r_rdata.size() == rb + 1) chk("post_rdata", r_rdata[rb], 32'h1357_9BDF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
